// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter_if
// Brief    : Request, shared-adder and response signals of adder_arbiter.
// Revision : 1.0
// ============================================================================
interface adder_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic [WIDTH-1:0]       add_sum;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_sum;
  logic                   rsp_ready;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

  // Requester / adder / consumer side
  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin arbiter sharing one combinational adder among
//            N_REQ requesters; one transaction in flight at a time.
// Revision : 1.0
// ============================================================================
module adder_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_arbiter_if.slave bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_valid;

  logic [ID_W-1:0]  w_cand;
  logic [ID_W-1:0]  w_win;
  logic             w_found;
  logic             w_grant;
  logic [N_REQ-1:0] w_req_ready;

  // Search starts at the pointer; N_REQ is a power of two so index wrap is free.
  always_comb begin
    w_cand  = r_ptr;
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = r_ptr + ID_W'(k);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !rst) begin
          w_grant            = 1'b1;
          w_req_ready[w_win] = 1'b1;
          w_state_nxt        = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (bus.rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr  <= w_win + ID_W'(1);
        r_id   <= w_win;
        r_op_a <= bus.req_a[w_win*WIDTH +: WIDTH];
        r_op_b <= bus.req_b[w_win*WIDTH +: WIDTH];
      end
      // The adder gets the whole ISSUE cycle to settle before its sum is taken.
      if (r_state == S_ISSUE) begin
        r_rsp_sum   <= bus.add_sum;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == S_HOLD && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.add_a     = r_op_a;
  assign bus.add_b     = r_op_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sum   = r_rsp_sum;

endmodule
`default_nettype wire
